dac_sample_pacer: RTL
=====================

// Module: dac_sample_pacer
// PURPOSE
//   Sits between the RISC-V core's 10-bit output and the avsddac D input.
//   Buffers core-written codes in a small FIFO and releases them to the DAC at
//   a fixed, programmable sample rate. The analog output therefore updates on a
//   regular grid, independent of core instruction timing. On underrun it holds
//   the last code and re-primes the FIFO.
// PARAMETERS
//   DEPTH       8     FIFO entries; power of 2, >= 2
//   PREFILL     4     entries required before RUN starts; 1..DEPTH
//   DIV_W       16    width of the sample-period divider input
//   RESET_CODE  10'd512  dac_d value after reset (mid-scale)
// PORTS
//   CLK          in   1      system clock from PLL
//   reset        in   1      synchronous, active-low; 0 = reset at posedge CLK
//   enable       in   1      1 = pacing active; 0 = forced to PRIME, FIFO keeps data
//   in_data      in   10     sample code from core
//   in_valid     in   1      in_data valid
//   in_ready     out  1      FIFO can accept; equals !full
//   div          in   DIV_W  sample period minus 1, in CLK cycles
//   dac_d        out  10     code to DAC D input; registered
//   dac_strobe   out  1      1-cycle pulse when dac_d loads a new sample
//   underrun     out  1      1-cycle pulse on a tick with an empty FIFO
//   fifo_level   out  log2(DEPTH)+1  current occupancy
// BEHAVIOUR
//   Reset (reset==0 at posedge CLK): FIFO emptied; state=PRIME; tick cnt=0.
//     Outputs: dac_d=RESET_CODE, dac_strobe=0, underrun=0, fifo_level=0,
//     in_ready=1.
//     Reset asserted mid-run discards all queued samples in the same edge.
//   Push: when in_valid && in_ready. in_ready=!full, with no same-cycle bypass.
//     A push is refused at full even if a pop occurs in that cycle.
//   Tick counter: counts only in RUN. tick = (cnt >= div); on tick cnt<=0,
//     else cnt<=cnt+1. div=0 gives a tick every cycle. Lowering div below cnt
//     gives a tick on the next cycle.
//   FSM:
//     PRIME: cnt held at 0, no pops.
//       -> RUN when enable && fifo_level >= PREFILL.
//     RUN: on tick with FIFO non-empty: pop head; dac_d <= head the same edge;
//       dac_strobe=1 the next cycle. The first sample appears div+1 cycles
//       after entering RUN.
//       On tick with FIFO empty: dac_d holds; underrun=1 for 1 cycle; -> PRIME.
//       enable==0 -> PRIME. cnt clears; dac_d holds.
//   Push and pop in the same cycle: level unchanged; both succeed if not full.
//   A push into an empty FIFO on a tick cycle still counts as an underrun.
//   Pointers wrap modulo DEPTH; fifo_level saturates logically at DEPTH (full).
//   dac_d changes only on a pop or on reset. It never glitches between samples.
// CONFIGURATION
//   DAC_PACER_UNDERRUN_CNT_EN
//     defined: adds output underrun_cnt [7:0]. It counts underrun pulses,
//       saturates at 8'hFF, and is cleared only by reset.
//     undefined: the port and counter are absent; all other behaviour is
//       identical.
// TESTING
//   1 Reset: hold reset=0 for 2 cycles -> dac_d=512, level=0, in_ready=1,
//     strobe=0.
//   2 Prime and pace: div=3, push 0x010..0x013 -> RUN. Strobes occur every
//     4 cycles with dac_d 0x010,0x011,0x012,0x013, in order.
//   3 Underrun: continue case 2 with no more pushes -> on the 5th tick,
//     underrun pulses, dac_d stays 0x013, state returns to PRIME. With
//     DAC_PACER_UNDERRUN_CNT_EN, underrun_cnt=1.
//   4 Full: enable=0, push 9 values with DEPTH=8 -> 9th refused, in_ready=0,
//     level=8. Set enable=1 and div=0 -> 8 strobes on consecutive cycles.
//   5 Wrap and concurrency: div=0, stream 20 pushes, one per cycle, after
//     priming -> outputs match the inputs in order, level steady at PREFILL,
//     no underrun.
//   6 Mid-run reset: reset=0 during RUN with level=3 -> next cycle level=0,
//     dac_d=512, no strobe.

Source files
------------

// File: rtl/dac_sample_pacer.sv
// dac_sample_pacer: FIFO-buffered DAC code pacer releasing samples on a programmable tick grid.
// Optional DAC_PACER_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module dac_sample_pacer #(
  parameter int         DEPTH      = 8,
  parameter int         PREFILL    = 4,
  parameter int         DIV_W      = 16,
  parameter logic [9:0] RESET_CODE = 10'd512
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [9:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DIV_W-1:0]         div,
  output logic [9:0]               dac_d,
  output logic                     dac_strobe,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   fifo_level
`ifdef DAC_PACER_UNDERRUN_CNT_EN
  ,
  output logic [7:0]               underrun_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic {PRIME, RUN} state_t;
  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic [9:0]       code_q, code_d;
  logic             strobe_q, strobe_d, und_q, und_d;
  logic [9:0]       mem_q [DEPTH];
  logic             full, empty, push, tick, pop;
  always_ff @(posedge CLK) begin
    if (!reset) state_q <= PRIME;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == PRIME) ? ((enable && lvl_q >= LW'(PREFILL)) ? RUN : PRIME)
                                 : ((!enable || (tick && empty)) ? PRIME : RUN);
  end
  // A tick only fires while actively pacing; leaving RUN clears the counter.
  always_comb begin
    full     = lvl_q == LW'(DEPTH);
    empty    = lvl_q == '0;
    push     = in_valid && !full;
    tick     = state_q == RUN && enable && cnt_q >= div;
    pop      = tick && !empty;
    cnt_d    = (state_q == RUN && enable && !tick) ? cnt_q + 1'b1 : '0;
    wr_d     = push ? wr_q + 1'b1 : wr_q;
    rd_d     = pop ? rd_q + 1'b1 : rd_q;
    lvl_d    = lvl_q + LW'(push) - LW'(pop);
    code_d   = pop ? mem_q[rd_q] : code_q;
    strobe_d = pop;
    und_d    = tick && empty;
  end
  always_ff @(posedge CLK) begin
    if (!reset) begin
      cnt_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      lvl_q    <= '0;
      code_q   <= RESET_CODE;
      strobe_q <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      lvl_q    <= lvl_d;
      code_q   <= code_d;
      strobe_q <= strobe_d;
      und_q    <= und_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_q] <= in_data;
  end
`ifdef DAC_PACER_UNDERRUN_CNT_EN
  logic [7:0] ucnt_q, ucnt_d;
  always_comb begin
    ucnt_d = (und_d && ucnt_q != 8'hFF) ? ucnt_q + 8'd1 : ucnt_q;
  end
  always_ff @(posedge CLK) begin
    if (!reset) ucnt_q <= '0;
    else ucnt_q <= ucnt_d;
  end
  assign underrun_cnt = ucnt_q;
`endif
  assign in_ready   = !full;
  assign dac_d      = code_q;
  assign dac_strobe = strobe_q;
  assign underrun   = und_q;
  assign fifo_level = lvl_q;
endmodule
